// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the inst/data sram-like bus arbiter.
package sram_bus_arbiter_pkg;
  localparam int SRAM_ADDR_W = 32;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_e;

  typedef struct packed {
    logic                   wr;
    logic [1:0]             size;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;
endpackage

// File: rtl/sram_bus_arbiter_if.sv
// One sram-like port: master drives the request, slave answers with addr_ok/data_ok/rdata.
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;

  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// In-order record of which requester owns each accepted-but-unanswered bus request.
module sram_bus_arbiter_owner_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_push,
  input  logic   i_pop,
  input  owner_e i_owner,
  output owner_e o_head,
  output logic   o_full,
  output logic   o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  owner_e             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [PTR_W:0]     r_count;
  logic               w_push, w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_owner;
  end
endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like master bus between inst and data requesters; responses routed in order.
// Optional: SRAM_ARB_RR_EN selects round-robin grant instead of fixed data-over-inst priority.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int MAX_OUTST = 4
) (
  input  logic clk,
  input  logic rst,
  sram_bus_arbiter_if.slave  inst_if,
  sram_bus_arbiter_if.slave  data_if,
  sram_bus_arbiter_if.master bus_if,
  output logic proto_err
);
  arb_state_e r_state, w_state_nx;
  owner_e     r_owner, w_owner_nx, w_idle_grant, w_grant, w_head;
  logic       r_proto_err;
  logic       w_gnt_req, w_bus_vld, w_accept, w_pop, w_full, w_empty;
  sram_req_t  w_inst_fld, w_data_fld, w_sel_fld;

`ifdef SRAM_ARB_RR_EN
  owner_e r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_last <= OWN_INST;
    else if (w_accept) r_last <= w_grant;
  end

  always_comb begin
    w_idle_grant = data_if.req ? OWN_DATA : OWN_INST;
    if (inst_if.req && data_if.req)
      w_idle_grant = (r_last == OWN_INST) ? OWN_DATA : OWN_INST;
  end
`else
  assign w_idle_grant = data_if.req ? OWN_DATA : OWN_INST;
`endif

  // A request left waiting for addr_ok keeps the bus until accepted or withdrawn.
  assign w_grant   = (r_state == ARB_LOCKED) ? r_owner : w_idle_grant;
  assign w_gnt_req = (w_grant == OWN_DATA) ? data_if.req : inst_if.req;
  assign w_bus_vld = rst & w_gnt_req & ~w_full;
  assign w_accept  = w_bus_vld & bus_if.addr_ok;
  assign w_pop     = bus_if.data_ok & ~w_empty;

  always_comb begin
    w_inst_fld = '{wr: inst_if.wr, size: inst_if.size, addr: inst_if.addr, wdata: inst_if.wdata};
    w_data_fld = '{wr: data_if.wr, size: data_if.size, addr: data_if.addr, wdata: data_if.wdata};
    w_sel_fld  = (w_grant == OWN_DATA) ? w_data_fld : w_inst_fld;
    if (!rst) w_sel_fld = '0;
  end

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    case (r_state)
      ARB_IDLE: if (w_bus_vld && !bus_if.addr_ok) begin
        w_state_nx = ARB_LOCKED;
        w_owner_nx = w_grant;
      end
      ARB_LOCKED: if (w_accept || !w_gnt_req) w_state_nx = ARB_IDLE;
      default: w_state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_INST;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      if (bus_if.data_ok && w_empty) r_proto_err <= 1'b1;
    end
  end

  sram_bus_arbiter_owner_fifo #(.DEPTH(MAX_OUTST)) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_owner (w_grant),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus_if.req   = w_bus_vld;
  assign bus_if.wr    = w_sel_fld.wr;
  assign bus_if.size  = w_sel_fld.size;
  assign bus_if.addr  = w_sel_fld.addr;
  assign bus_if.wdata = w_sel_fld.wdata;

  assign inst_if.addr_ok = w_accept & (w_grant == OWN_INST);
  assign data_if.addr_ok = w_accept & (w_grant == OWN_DATA);
  assign inst_if.data_ok = w_pop & (w_head == OWN_INST);
  assign data_if.data_ok = w_pop & (w_head == OWN_DATA);
  assign inst_if.rdata   = rst ? bus_if.rdata : '0;
  assign data_if.rdata   = rst ? bus_if.rdata : '0;
  assign proto_err       = r_proto_err;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_sram_bus_arbiter;
  localparam int MAXO = 4;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic proto_err;

  sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
  sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
  sram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(MAXO)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_if   (inst_if),
    .data_if   (data_if),
    .bus_if    (bus_if),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: owners of outstanding requests (1 = data, 0 = inst), in issue order.
  bit mq[$];
  bit m_locked, m_lock_own, m_last, m_perr;
  bit e_gnt, e_req, e_acc, e_pop, e_head;

  function automatic bit req_of(bit own);
    return own ? data_if.req : inst_if.req;
  endfunction

  task automatic model_eval();
    if (m_locked)                       e_gnt = m_lock_own;
    else if (inst_if.req && data_if.req) e_gnt = RR ? ~m_last : 1'b1;
    else                                e_gnt = data_if.req;
    e_req  = req_of(e_gnt) && (mq.size() < MAXO);
    e_acc  = e_req && bus_if.addr_ok;
    e_pop  = bus_if.data_ok && (mq.size() != 0);
    e_head = e_pop ? mq[0] : 1'b0;
  endtask

  task automatic model_commit();
    if (bus_if.data_ok && mq.size() == 0) m_perr = 1'b1;
    if (e_pop) void'(mq.pop_front());
    if (e_acc) begin
      mq.push_back(e_gnt);
      m_last   = e_gnt;
      m_locked = 1'b0;
    end else if (m_locked && !req_of(m_lock_own)) begin
      m_locked = 1'b0;
    end else if (!m_locked && e_req) begin
      m_locked   = 1'b1;
      m_lock_own = e_gnt;
    end
  endtask

  task automatic idle_in();
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.addr = 0; inst_if.wdata = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2; data_if.addr = 0; data_if.wdata = 0;
    bus_if.rdata = 0; bus_if.addr_ok = 0; bus_if.data_ok = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_in(); rst = 0;
    @(negedge clk); rst = 1;
    mq.delete(); m_locked = 0; m_lock_own = 0; m_last = 0; m_perr = 0;
  endtask

  task automatic test_reset();
    idle_in();
    inst_if.req = 1; data_if.req = 1; inst_if.addr = 32'h55;
    bus_if.addr_ok = 1; bus_if.data_ok = 1; bus_if.rdata = 32'h1234;
    #2 rst = 0;
    @(negedge clk); #1;
    n_tot++; if (bus_if.req !== 1'b0) $display("FAIL reset.bus_req got %0b exp 0", bus_if.req); else n_pass++;
    n_tot++; if (bus_if.addr !== 32'h0) $display("FAIL reset.bus_addr got %h exp 0", bus_if.addr); else n_pass++;
    n_tot++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b00) $display("FAIL reset.addr_ok got %b exp 00", {inst_if.addr_ok, data_if.addr_ok}); else n_pass++;
    n_tot++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) $display("FAIL reset.data_ok got %b exp 00", {inst_if.data_ok, data_if.data_ok}); else n_pass++;
    n_tot++; if (inst_if.rdata !== 32'h0) $display("FAIL reset.rdata got %h exp 0", inst_if.rdata); else n_pass++;
    n_tot++; if (proto_err !== 1'b0) $display("FAIL reset.proto_err got %b exp 0", proto_err); else n_pass++;
    do_reset();
    @(negedge clk); #1;
    n_tot++; if ({bus_if.req, proto_err} !== 2'b00) $display("FAIL reset.after_release got %b exp 00", {bus_if.req, proto_err}); else n_pass++;
  endtask

  task automatic test_inst_only();
    do_reset();
    @(negedge clk); inst_if.req = 1; inst_if.addr = 32'hBFC00000; bus_if.addr_ok = 0; #1;
    n_tot++; if ({bus_if.req, bus_if.addr} !== {1'b1, 32'hBFC00000}) $display("FAIL inst_only.fwd got %b/%h exp 1/bfc00000", bus_if.req, bus_if.addr); else n_pass++;
    n_tot++; if (inst_if.addr_ok !== 1'b0) $display("FAIL inst_only.early_addr_ok got %b exp 0", inst_if.addr_ok); else n_pass++;
    @(negedge clk); bus_if.addr_ok = 1; #1;
    n_tot++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10) $display("FAIL inst_only.addr_ok got %b exp 10", {inst_if.addr_ok, data_if.addr_ok}); else n_pass++;
    @(negedge clk); inst_if.req = 0; bus_if.addr_ok = 0; bus_if.data_ok = 1; bus_if.rdata = 32'h3C1D0000; #1;
    n_tot++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b10) $display("FAIL inst_only.data_ok got %b exp 10", {inst_if.data_ok, data_if.data_ok}); else n_pass++;
    n_tot++; if (inst_if.rdata !== 32'h3C1D0000) $display("FAIL inst_only.rdata got %h exp 3c1d0000", inst_if.rdata); else n_pass++;
    n_tot++; if ({inst_if.addr_ok, bus_if.req} !== 2'b00) $display("FAIL inst_only.quiet got %b exp 00", {inst_if.addr_ok, bus_if.req}); else n_pass++;
    @(negedge clk); bus_if.data_ok = 0; #1;
    n_tot++; if (inst_if.data_ok !== 1'b0) $display("FAIL inst_only.data_ok_once got %b exp 0", inst_if.data_ok); else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge clk); inst_if.req = 1; inst_if.addr = 32'h1000; data_if.req = 1; data_if.addr = 32'h2000; bus_if.addr_ok = 1; #1;
    n_tot++; if (bus_if.addr !== 32'h2000) $display("FAIL prio.first_addr got %h exp 2000", bus_if.addr); else n_pass++;
    n_tot++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01) $display("FAIL prio.first_ok got %b exp 01", {inst_if.addr_ok, data_if.addr_ok}); else n_pass++;
    @(negedge clk); data_if.req = 0; #1;
    n_tot++; if ({bus_if.addr, inst_if.addr_ok} !== {32'h1000, 1'b1}) $display("FAIL prio.second got %h/%b exp 1000/1", bus_if.addr, inst_if.addr_ok); else n_pass++;
    @(negedge clk); idle_in(); bus_if.data_ok = 1; bus_if.rdata = 32'hAAAA0001; #1;
    n_tot++; if ({inst_if.data_ok, data_if.data_ok, data_if.rdata} !== {2'b01, 32'hAAAA0001}) $display("FAIL prio.resp_a got %b/%h exp 01/aaaa0001", {inst_if.data_ok, data_if.data_ok}, data_if.rdata); else n_pass++;
    @(negedge clk); bus_if.rdata = 32'hBBBB0002; #1;
    n_tot++; if ({inst_if.data_ok, data_if.data_ok, inst_if.rdata} !== {2'b10, 32'hBBBB0002}) $display("FAIL prio.resp_b got %b/%h exp 10/bbbb0002", {inst_if.data_ok, data_if.data_ok}, inst_if.rdata); else n_pass++;
  endtask

  task automatic test_lock();
    do_reset();
    @(negedge clk); inst_if.req = 1; inst_if.addr = 32'h3000; #1;
    n_tot++; if (bus_if.addr !== 32'h3000) $display("FAIL lock.c0_addr got %h exp 3000", bus_if.addr); else n_pass++;
    @(negedge clk); data_if.req = 1; data_if.addr = 32'h4000; #1;
    n_tot++; if ({bus_if.addr, data_if.addr_ok} !== {32'h3000, 1'b0}) $display("FAIL lock.c1 got %h/%b exp 3000/0", bus_if.addr, data_if.addr_ok); else n_pass++;
    @(negedge clk); bus_if.addr_ok = 1; #1;
    n_tot++; if ({bus_if.addr, inst_if.addr_ok, data_if.addr_ok} !== {32'h3000, 2'b10}) $display("FAIL lock.accept got %h/%b exp 3000/10", bus_if.addr, {inst_if.addr_ok, data_if.addr_ok}); else n_pass++;
    @(negedge clk); inst_if.req = 0; #1;
    n_tot++; if ({bus_if.addr, data_if.addr_ok} !== {32'h4000, 1'b1}) $display("FAIL lock.next got %h/%b exp 4000/1", bus_if.addr, data_if.addr_ok); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_in(); bus_if.addr_ok = 1;
      if (i % 2 == 0) begin data_if.req = 1; data_if.addr = 32'h100 + i; end
      else begin inst_if.req = 1; inst_if.addr = 32'h200 + i; end
      #1;
      n_tot++; if ({inst_if.addr_ok, data_if.addr_ok} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL full.fill%0d got %b", i, {inst_if.addr_ok, data_if.addr_ok}); else n_pass++;
    end
    @(negedge clk); inst_if.req = 1; data_if.req = 1; #1;
    n_tot++; if ({bus_if.req, inst_if.addr_ok, data_if.addr_ok} !== 3'b000) $display("FAIL full.blocked got %b exp 000", {bus_if.req, inst_if.addr_ok, data_if.addr_ok}); else n_pass++;
    @(negedge clk); bus_if.data_ok = 1; bus_if.rdata = 32'hA0; #1;
    n_tot++; if ({bus_if.req, inst_if.data_ok, data_if.data_ok} !== 3'b001) $display("FAIL full.pop_while_full got %b exp 001", {bus_if.req, inst_if.data_ok, data_if.data_ok}); else n_pass++;
    @(negedge clk); bus_if.rdata = 32'hA1; data_if.addr = 32'h300; #1;
    n_tot++; if ({bus_if.addr, data_if.addr_ok, inst_if.data_ok} !== {32'h300, 2'b11}) $display("FAIL full.push_pop got %h/%b exp 300/11", bus_if.addr, {data_if.addr_ok, inst_if.data_ok}); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); inst_if.req = 0; data_if.req = 0; bus_if.data_ok = 1; #1;
      n_tot++; if ({inst_if.data_ok, data_if.data_ok} !== ((i == 1) ? 2'b10 : 2'b01)) $display("FAIL full.drain%0d got %b", i, {inst_if.data_ok, data_if.data_ok}); else n_pass++;
    end
    @(negedge clk); bus_if.data_ok = 0; #1;
    n_tot++; if (proto_err !== 1'b0) $display("FAIL full.proto_err got %b exp 0", proto_err); else n_pass++;
  endtask

  task automatic test_proto_err();
    do_reset();
    @(negedge clk); bus_if.data_ok = 1; bus_if.rdata = 32'hDEAD; #1;
    n_tot++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) $display("FAIL perr.no_data_ok got %b exp 00", {inst_if.data_ok, data_if.data_ok}); else n_pass++;
    @(negedge clk); bus_if.data_ok = 0; #1;
    n_tot++; if (proto_err !== 1'b1) $display("FAIL perr.set got %b exp 1", proto_err); else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    n_tot++; if (proto_err !== 1'b1) $display("FAIL perr.sticky got %b exp 1", proto_err); else n_pass++;
    rst = 0; #1;
    n_tot++; if (proto_err !== 1'b0) $display("FAIL perr.cleared got %b exp 0", proto_err); else n_pass++;
    rst = 1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); inst_if.req = 1; data_if.req = 1; bus_if.addr_ok = 1; #1;
      n_tot++; if ({inst_if.addr_ok, data_if.addr_ok} !== ((RR && i % 2 == 1) ? 2'b10 : 2'b01)) $display("FAIL b2b.grant%0d got %b", i, {inst_if.addr_ok, data_if.addr_ok}); else n_pass++;
    end
    @(negedge clk); bus_if.data_ok = 1; bus_if.rdata = 32'h77; rst = 0; #1;
    n_tot++; if ({bus_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok} !== 5'b0) $display("FAIL b2b.reset_ctl got %b exp 00000", {bus_if.req, inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok}); else n_pass++;
    n_tot++; if ({bus_if.addr, data_if.rdata} !== 64'h0) $display("FAIL b2b.reset_data got %h/%h exp 0/0", bus_if.addr, data_if.rdata); else n_pass++;
    @(negedge clk); rst = 1; inst_if.req = 0; data_if.req = 0; bus_if.addr_ok = 0; #1;
    n_tot++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) $display("FAIL b2b.fifo_flushed got %b exp 00", {inst_if.data_ok, data_if.data_ok}); else n_pass++;
    @(negedge clk); bus_if.data_ok = 0; inst_if.req = 1; bus_if.addr_ok = 1; #1;
    n_tot++; if ({proto_err, inst_if.addr_ok} !== 2'b11) $display("FAIL b2b.after_reset got %b exp 11", {proto_err, inst_if.addr_ok}); else n_pass++;
  endtask

  task automatic test_random();
    logic [36:0] exp_fld;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_tot++; if (proto_err !== m_perr) $display("FAIL rand.proto_err cyc %0d got %b exp %b", c, proto_err, m_perr); else n_pass++;
      inst_if.req = ($urandom_range(0, 9) < 6); inst_if.wr = 1'($urandom_range(0, 1));
      inst_if.size = 2'($urandom_range(0, 2)); inst_if.addr = $urandom; inst_if.wdata = $urandom;
      data_if.req = ($urandom_range(0, 9) < 6); data_if.wr = 1'($urandom_range(0, 1));
      data_if.size = 2'($urandom_range(0, 2)); data_if.addr = $urandom; data_if.wdata = $urandom;
      bus_if.addr_ok = 1'($urandom_range(0, 1));
      bus_if.data_ok = ($urandom_range(0, 9) < 4);
      bus_if.rdata = $urandom;
      #1;
      model_eval();
      n_tot++; if (bus_if.req !== e_req) $display("FAIL rand.bus_req cyc %0d got %b exp %b", c, bus_if.req, e_req); else n_pass++;
      n_tot++; if ({inst_if.addr_ok, data_if.addr_ok} !== {e_acc & ~e_gnt, e_acc & e_gnt}) $display("FAIL rand.addr_ok cyc %0d got %b exp %b", c, {inst_if.addr_ok, data_if.addr_ok}, {e_acc & ~e_gnt, e_acc & e_gnt}); else n_pass++;
      n_tot++; if ({inst_if.data_ok, data_if.data_ok} !== {e_pop & ~e_head, e_pop & e_head}) $display("FAIL rand.data_ok cyc %0d got %b exp %b", c, {inst_if.data_ok, data_if.data_ok}, {e_pop & ~e_head, e_pop & e_head}); else n_pass++;
      if (e_req) begin
        exp_fld = e_gnt ? {data_if.wr, data_if.size, data_if.addr} : {inst_if.wr, inst_if.size, inst_if.addr};
        n_tot++; if ({bus_if.wr, bus_if.size, bus_if.addr} !== exp_fld[34:0]) $display("FAIL rand.bus_fields cyc %0d got %h exp %h", c, {bus_if.wr, bus_if.size, bus_if.addr}, exp_fld[34:0]); else n_pass++;
        n_tot++; if (bus_if.wdata !== (e_gnt ? data_if.wdata : inst_if.wdata)) $display("FAIL rand.bus_wdata cyc %0d got %h", c, bus_if.wdata); else n_pass++;
      end
      if (e_pop) begin
        n_tot++; if ((e_head ? data_if.rdata : inst_if.rdata) !== bus_if.rdata) $display("FAIL rand.rdata cyc %0d exp %h", c, bus_if.rdata); else n_pass++;
      end
      model_commit();
    end
  endtask

  initial begin
    idle_in();
    test_reset();
    test_inst_only();
    test_priority();
    test_lock();
    test_full();
    test_proto_err();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
